pix_feeder: RTL and testbench
=============================

# pix_feeder

Upstream stage of the pixel path: buffers bytes from a host stream in a small FIFO and presents them to the pixel processor one per cycle on `pixel_in`/`pix_req`, paced into lines. It pulses `start_dec` with the first pixel of every line and inserts a fixed blanking gap between lines. Its outputs connect directly to the processor's `pixel_in`, `pix_req` and `start_dec` inputs.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `LINE_LEN`, 16: pixels per line; ≥ 2.
- `GAP`, 2: blanking cycles between lines; ≥ 1.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: enables pixel issue; does not affect FIFO writes or gap countdown.
- `s_valid` in 1: host byte valid.
- `s_data` in 8: host byte.
- `s_ready` out 1: FIFO can accept; `count < DEPTH`.
- `pixel_in` out 8: registered pixel byte to the processor.
- `pix_req` out 1: registered, high for one cycle per issued pixel.
- `start_dec` out 1: registered; high together with `pix_req` on the first pixel of a line.
- `level` out clog2(DEPTH)+1: current FIFO occupancy `count`.

## Operation
- Reset (edge with `rst`=1): `count`, read pointer and write pointer = 0; `pix_cnt` = 0; `gap_cnt` = 0; state = IDLE; `pixel_in` = 8'h00; `pix_req` = 0; `start_dec` = 0. `s_ready` = 1 after reset. FIFO contents are not cleared. Reset takes priority over every event and drops a line in progress.
- Write: `wr = s_valid & s_ready`. On a write, store `s_data` at the write pointer; the pointer wraps modulo DEPTH.
- `s_ready` depends only on the registered `count`, never on the same-cycle read. A full FIFO therefore refuses a write even in a cycle where it pops.
- Pop: `rd = (state==RUN) & en & (count>0)`. On a pop:
  - `pixel_in` ← head entry.
  - `pix_req` ← 1.
  - `start_dec` ← (`pix_cnt`==0).
  - Read pointer advances and wraps.
- Without a pop, `pix_req` ← 0 and `start_dec` ← 0, and `pixel_in` holds its value.
- Count update: `count` += `wr` − `rd`. A simultaneous read and write leaves `count` unchanged.
- State IDLE: go to RUN when `en & count>0`; no pop happens in that cycle.
- State RUN: pops as above.
  - On a pop with `pix_cnt`==LINE_LEN−1: `pix_cnt` ← 0, `gap_cnt` ← GAP−1, go to GAP.
  - Other pops: `pix_cnt` += 1.
  - `en`=0 or an empty FIFO stalls in RUN, keeping `pix_cnt`; a line resumes mid-line.
- State GAP: no pops. If `gap_cnt`==0, go to RUN; otherwise `gap_cnt` −= 1. GAP lasts exactly GAP cycles.
- Widths: `pix_cnt` is clog2(LINE_LEN) bits, `gap_cnt` is clog2(GAP)+1 bits, `count` is clog2(DEPTH)+1 bits. All arithmetic is unsigned and non-saturating; the protocol guarantees no overflow.

## Timing
- Registered outputs change one edge after the pop decision.
- Latency from IDLE with an empty FIFO:
  - Byte accepted at edge E.
  - RUN entered at E+1.
  - Pop at E+2; `pix_req`=1 during the cycle after E+2.
- Latency while in RUN with an empty FIFO: byte accepted at E, popped at E+1, `pix_req` visible after E+1.
- Steady state with a non-empty FIFO and `en`=1: LINE_LEN consecutive `pix_req` cycles, then GAP cycles of 0, repeating.
- `start_dec` never asserts without `pix_req`.

## Structure
- Shared package holds:
  - state encoding `IDLE`=2'd0, `RUN`=2'd1, `GAP`=2'd2 (2'd3 unused, decodes to IDLE);
  - default constants `PIX_DEPTH`=4, `PIX_LINE_LEN`=16, `PIX_GAP`=2.
- Sub-module `pix_fifo`: DEPTH×8 storage, pointers, `count`, `s_ready`; ports `wr`, `rd`, `din`, `dout`, `count`.
- The FSM, counters and output registers stay in `pix_feeder`.

## Test plan
All scenarios use DEPTH=4, LINE_LEN=4, GAP=2.
- Reset then idle: `s_valid`=0, `en`=1 for 10 cycles → `pix_req`=0, `start_dec`=0, `pixel_in`=00, `level`=0, `s_ready`=1 throughout.
- Single byte: push 8'hA5 at edge E from IDLE → `pix_req`=1 and `start_dec`=1 with `pixel_in`=A5 exactly after edge E+2, for one cycle; `level` returns to 0.
- Line pacing: preload 8 bytes 01..08 (FIFO full after 4; `s_ready`=0 while `level`=4), keep `s_valid`=1 with `en`=1.
  - `pix_req` pattern is 1,1,1,1,0,0,1,1,1,1.
  - `start_dec` is high only with 01 and 05.
  - Data arrives in order.
- Full plus simultaneous: with `level`=4 and pops active, `s_valid`=1 → no write until `level`=3. Then a write and a pop in the same cycle keep `level`=3; no byte is lost or duplicated over 12 bytes.
- Stall: `en`=0 after the 2nd pixel of a line for 5 cycles → no `pix_req`. After `en`=1, pixels 3 and 4 are issued without `start_dec`, then 2 gap cycles follow.
- Reset mid-line: assert `rst` after the 3rd pixel with `level`=2 → next cycle all outputs are 0 and `level`=0. The next pushed byte is issued with `start_dec`=1.

Source files
------------

// File: rtl/pix_feeder_pkg.sv
// Shared definitions for the pixel feeder: FSM state encoding and default sizing.
package pix_feeder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam int unsigned PIX_DEPTH    = 4;
  localparam int unsigned PIX_LINE_LEN = 16;
  localparam int unsigned PIX_GAP      = 2;

endpackage

// File: rtl/pix_feeder_fifo.sv
// Small byte FIFO: DEPTH x 8 storage, wrapping pointers and occupancy count.
import pix_feeder_pkg::*;

module pix_fifo #(
  parameter int unsigned DEPTH = PIX_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic                     rd,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     s_ready
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  // Readiness comes only from the registered count, so a full FIFO refuses
  // a write even in a cycle where it also pops.
  assign s_ready = (count < (AW + 1)'(DEPTH));
  assign dout    = mem[rptr];

  // Storage write; contents are deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pix_feeder.sv
// Pixel feeder: drains the byte FIFO one pixel per cycle, paced into lines
// of LINE_LEN pixels separated by GAP blanking cycles.
import pix_feeder_pkg::*;

module pix_feeder #(
  parameter int unsigned DEPTH    = PIX_DEPTH,
  parameter int unsigned LINE_LEN = PIX_LINE_LEN,
  parameter int unsigned GAP      = PIX_GAP
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     s_valid,
  input  logic [7:0]               s_data,
  output logic                     s_ready,
  output logic [7:0]               pixel_in,
  output logic                     pix_req,
  output logic                     start_dec,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PW = $clog2(LINE_LEN);
  localparam int unsigned GW = $clog2(GAP) + 1;

  state_t        state;
  state_t        state_next;
  logic          wr;
  logic          rd;
  logic          last_pix;
  logic [7:0]    head;
  logic [PW-1:0] pix_cnt;
  logic [GW-1:0] gap_cnt;

  assign wr       = s_valid & s_ready;
  assign last_pix = (pix_cnt == PW'(LINE_LEN - 1));

  pix_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr      (wr),
    .rd      (rd),
    .din     (s_data),
    .dout    (head),
    .count   (level),
    .s_ready (s_ready)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next state and pop decision; the unused encoding behaves as IDLE.
  always_comb begin
    rd         = 1'b0;
    state_next = state;
    case (state)
      S_RUN: begin
        rd = en && (level != '0);
        if (rd && last_pix) state_next = S_GAP;
      end
      S_GAP: begin
        if (gap_cnt == '0) state_next = S_RUN;
      end
      default: begin
        state_next = S_IDLE;
        if (en && (level != '0)) state_next = S_RUN;
      end
    endcase
  end

  // Line position and blanking countdown.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      if (rd) pix_cnt <= last_pix ? '0 : pix_cnt + 1'b1;
      if (rd && last_pix)
        gap_cnt <= GW'(GAP - 1);
      else if ((state == S_GAP) && (gap_cnt != '0))
        gap_cnt <= gap_cnt - 1'b1;
    end
  end

  // Registered pixel outputs; pixel_in holds between pops.
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_in  <= 8'h00;
      pix_req   <= 1'b0;
      start_dec <= 1'b0;
    end else begin
      pix_req   <= rd;
      start_dec <= rd && (pix_cnt == '0);
      if (rd) pixel_in <= head;
    end
  end

endmodule

// File: tb/tb_pix_feeder.sv
// Self-checking bench for pix_feeder with DEPTH=4, LINE_LEN=4, GAP=2.
module tb_pix_feeder;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned LINE_LEN = 4;
  localparam int unsigned GAP      = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_ready;
  logic [7:0] pixel_in;
  logic       pix_req;
  logic       start_dec;
  logic [2:0] level;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] sb[$];
  logic [7:0] fbuf [16];
  int         fidx = 0;
  int         fn = 0;
  int         line_pos = 0;
  int         gap_left = 0;
  logic       mon_on = 1'b0;

  pix_feeder #(
    .DEPTH    (DEPTH),
    .LINE_LEN (LINE_LEN),
    .GAP      (GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .pixel_in  (pixel_in),
    .pix_req   (pix_req),
    .start_dec (start_dec),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Load the host byte source with n consecutive values starting at base.
  task automatic set_feed(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) fbuf[i] = base + 8'(i);
    fn   = n;
    fidx = 0;
  endtask

  // One clock: present the next source byte, record it on acceptance, step.
  task automatic cyc();
    if (fidx < fn) begin
      s_valid = 1'b1;
      s_data  = fbuf[fidx];
      if (s_ready) begin
        sb.push_back(fbuf[fidx]);
        fidx++;
      end
    end else begin
      s_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    sb.delete();
    line_pos = 0;
    gap_left = 0;
    fn       = 0;
    fidx     = 0;
    mon_on   = 1'b1;
  endtask

  // Output monitor: data order, line starts and blanking, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_on) begin
      if (!pix_req) check_eq("start_without_req", start_dec, 1'b0);
      if (gap_left > 0) begin
        check_eq("gap_req", pix_req, 1'b0);
        gap_left--;
      end else if (pix_req) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_pixel", 32'(pixel_in), 32'hFFFF);
        end else begin
          check_eq("data", pixel_in, sb.pop_front());
        end
        check_eq("start_dec", start_dec, line_pos == 0);
        line_pos = (line_pos + 1) % LINE_LEN;
        if (line_pos == 0) gap_left = GAP;
      end
    end
  end

  logic [9:0] pat;
  bit         found;

  initial begin
    pat = 10'b1111001111;

    // Reset then idle
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check_eq("idle_req", pix_req, 1'b0);
      check_eq("idle_start", start_dec, 1'b0);
      check_eq("idle_pixel", pixel_in, 8'h00);
      check_eq("idle_level", level, 3'd0);
      check_eq("idle_ready", s_ready, 1'b1);
    end

    // Single byte latency from IDLE
    do_reset();
    en = 1'b1;
    set_feed(1, 8'hA5);
    cyc();
    check_eq("single_e0_req", pix_req, 1'b0);
    check_eq("single_e0_level", level, 3'd1);
    cyc();
    check_eq("single_e1_req", pix_req, 1'b0);
    cyc();
    check_eq("single_e2_req", pix_req, 1'b1);
    check_eq("single_e2_start", start_dec, 1'b1);
    check_eq("single_e2_pixel", pixel_in, 8'hA5);
    check_eq("single_e2_level", level, 3'd0);
    cyc();
    check_eq("single_e3_req", pix_req, 1'b0);
    check_eq("single_hold_pixel", pixel_in, 8'hA5);

    // Line pacing, full FIFO and simultaneous read/write over 12 bytes
    do_reset();
    en = 1'b0;
    set_feed(12, 8'h01);
    for (int i = 0; i < 4; i++) cyc();
    check_eq("full_level", level, 3'd4);
    check_eq("full_ready", s_ready, 1'b0);
    cyc();
    check_eq("full_no_write", level, 3'd4);
    en = 1'b1;
    cyc();
    check_eq("pace_enter_req", pix_req, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      check_eq("pace_req", pix_req, pat[9 - i]);
      check_eq("pace_start", start_dec, (i == 0) || (i == 6));
      if (i < 2) check_eq("pace_level", level, 3'd3);
    end
    for (int k = 0; k < 40 && (sb.size() != 0 || fidx < fn); k++) cyc();
    check_eq("pace_drain", 32'(sb.size()) + 32'(fn - fidx), 32'd0);

    // Stall mid-line
    do_reset();
    en = 1'b0;
    set_feed(6, 8'h21);
    for (int i = 0; i < 4; i++) cyc();
    en = 1'b1;
    cyc();
    cyc();
    check_eq("stall_p1", pixel_in, 8'h21);
    cyc();
    check_eq("stall_p2", pixel_in, 8'h22);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check_eq("stall_req", pix_req, 1'b0);
    end
    en = 1'b1;
    cyc();
    check_eq("stall_p3_req", pix_req, 1'b1);
    check_eq("stall_p3_start", start_dec, 1'b0);
    check_eq("stall_p3_pixel", pixel_in, 8'h23);
    cyc();
    check_eq("stall_p4_start", start_dec, 1'b0);
    check_eq("stall_p4_pixel", pixel_in, 8'h24);
    cyc();
    check_eq("stall_gap1", pix_req, 1'b0);
    cyc();
    check_eq("stall_gap2", pix_req, 1'b0);
    cyc();
    check_eq("stall_next_line", start_dec, 1'b1);
    check_eq("stall_next_pixel", pixel_in, 8'h25);

    // Reset mid-line
    do_reset();
    en = 1'b0;
    set_feed(5, 8'h11);
    for (int i = 0; i < 4; i++) cyc();
    en = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    check_eq("mid_p3_req", pix_req, 1'b1);
    check_eq("mid_p3_pixel", pixel_in, 8'h13);
    check_eq("mid_p3_level", level, 3'd2);
    do_reset();
    check_eq("rst_req", pix_req, 1'b0);
    check_eq("rst_start", start_dec, 1'b0);
    check_eq("rst_pixel", pixel_in, 8'h00);
    check_eq("rst_level", level, 3'd0);
    check_eq("rst_ready", s_ready, 1'b1);
    en = 1'b1;
    set_feed(1, 8'h77);
    found = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      cyc();
      if (pix_req) begin
        found = 1'b1;
        check_eq("post_rst_start", start_dec, 1'b1);
        check_eq("post_rst_pixel", pixel_in, 8'h77);
      end
    end
    check_eq("post_rst_issued", found, 1'b1);
    cyc();
    cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
